// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path (and its transmit-side
//   siblings): frame geometry, oversampling ratio, receiver FSM state
//   encoding and the clock-divider derivation used by every baud-rate
//   generator in the UART.
//
//   Contents
//     DATA_BITS     data bits per frame (8N1 framing)
//     OVERSAMPLE    line samples per bit; the receiver only supports 16
//     SCNT_MID      oversample index at the middle of a bit
//     SCNT_LAST     oversample index at the end of a bit period
//     rx_state_t    receiver FSM states
//     calc_div()    clocks per oversample tick for a given clock/baud pair
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Mid-bit and end-of-bit positions within one 16x oversampled bit.
    localparam logic [3:0] SCNT_MID  = 4'd7;
    localparam logic [3:0] SCNT_LAST = 4'd15;

    // Index of the final data bit in the 3-bit data-bit counter.
    localparam logic [2:0] BCNT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // line idle, watching for a falling edge
        ST_START = 3'd1,   // qualifying the start bit at its midpoint
        ST_DATA  = 3'd2,   // shifting in the eight data bits
        ST_STOP  = 3'd3,   // sampling the stop bit
        ST_BRK   = 3'd4    // framing error: wait for the line to go high
    } rx_state_t;

    // Clocks per oversample tick. Integer truncation is intentional so that
    // transmitter and receiver built from the same CLK_HZ/BAUD agree exactly.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the serial line, the consumer handshake and the status flags of
//   the UART receiver.
//
//   Signals
//     Rx         serial input, idles high (driven by the line / master)
//     Rd_en      one-cycle acknowledge from the consumer (master)
//     Rx_data    last good byte received (receiver)
//     Rx_ready   a byte is waiting to be acknowledged (receiver)
//     Rx_busy    receiver FSM is not idle (receiver)
//     Frame_err  sticky framing error (receiver)
//     Overrun    sticky overrun: a byte landed while one was pending (receiver)
//
//   Modports
//     master     the consumer side: drives Rx and Rd_en
//     slave      the receiver side: drives data and status
// ---------------------------------------------------------------------------
interface uart_receiver_if;

    logic       Rx;
    logic       Rd_en;
    logic [7:0] Rx_data;
    logic       Rx_ready;
    logic       Rx_busy;
    logic       Frame_err;
    logic       Overrun;

    modport master (
        output Rx,
        output Rd_en,
        input  Rx_data,
        input  Rx_ready,
        input  Rx_busy,
        input  Frame_err,
        input  Overrun
    );

    modport slave (
        input  Rx,
        input  Rd_en,
        output Rx_data,
        output Rx_ready,
        output Rx_busy,
        output Frame_err,
        output Overrun
    );

endinterface : uart_receiver_if

// File: rtl/uart_receiver_baud_tick.sv
// ---------------------------------------------------------------------------
// rx_baud_tick
//   Oversample tick generator for the UART receiver. Emits a one-cycle pulse
//   every DIV clocks, DIV = CLK_HZ / (BAUD * 16). The counter free-runs from
//   reset and is never re-phased to the incoming frame; the receiver's 16x
//   oversampling absorbs the up-to-one-tick phase uncertainty.
//
//   Ports
//     clk_50m  in   system clock
//     clr      in   synchronous active-high reset
//     tick     out  one-cycle pulse every DIV clocks
// ---------------------------------------------------------------------------
module rx_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic clk_50m,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_50m) begin
        if (clr) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule : rx_baud_tick

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receive path. The asynchronous Rx line is brought into the
//   clock domain through a two-flop synchroniser, oversampled at 16x, the
//   start bit is qualified at its midpoint and the data bits are sampled at
//   16-tick intervals from there (i.e. at their centres). Bytes arrive
//   LSB first. A completed byte is held on Rx_data with Rx_ready high until
//   the consumer pulses Rd_en.
//
//   Ports
//     clk_50m    in   system clock, all logic on the rising edge
//     clr        in   synchronous active-high reset
//     rx_if      slave modport of uart_receiver_if:
//                  Rx, Rd_en                 in
//                  Rx_data[7:0], Rx_ready,
//                  Rx_busy, Frame_err,
//                  Overrun                   out
//
//   Flag behaviour
//     Rx_ready   set on a good byte, cleared by Rd_en. A good byte in the
//                same cycle as Rd_en keeps it set (the new byte is pending).
//     Overrun    set when a good byte lands while Rx_ready is already set
//                and not being acknowledged in that cycle.
//     Frame_err  set when the stop bit samples low; the byte is discarded
//                and the FSM waits in BRK for the line to return high, so a
//                held-low (break) line is never mistaken for a new start bit.
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic         clk_50m,
    input  logic         clr,
    uart_receiver_if.slave rx_if
);

    logic       tick;
    logic       rx_m;
    logic       rx_s;
    rx_state_t  state;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       shift_en;

    rx_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tick (
        .clk_50m (clk_50m),
        .clr     (clr),
        .tick    (tick)
    );

    // Two-flop synchroniser; presets to the idle (high) line level so that
    // coming out of reset never looks like a start bit.
    always_ff @(posedge clk_50m) begin
        if (clr) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_if.Rx;
            rx_s <= rx_m;
        end
    end

    // Data bits are sampled at the end of each 16-tick bit period measured
    // from the start-bit midpoint, which places them at the bit centres.
    assign shift_en = (state == ST_DATA) && tick && (scnt == SCNT_LAST);

    // Shift register carries only data; it is fully refilled before every
    // capture, so it needs no reset.
    always_ff @(posedge clk_50m) begin
        if (shift_en) begin
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Receiver FSM with its counters and registered outputs.
    always_ff @(posedge clk_50m) begin
        if (clr) begin
            state     <= ST_IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Acknowledge; any event below in the same cycle overrides it.
            if (rx_if.Rd_en) begin
                rx_ready  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        scnt    <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (scnt == SCNT_MID) begin
                            if (!rx_s) begin
                                state <= ST_DATA;
                                scnt  <= '0;
                                bcnt  <= '0;
                            end else begin
                                // Low pulse shorter than half a bit: noise.
                                state   <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == SCNT_LAST) begin
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == BCNT_LAST) begin
                                state <= ST_STOP;
                                scnt  <= '0;
                            end
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == SCNT_LAST) begin
                            if (rx_s) begin
                                rx_data  <= shreg;
                                rx_ready <= 1'b1;
                                // An ack coinciding with the new byte consumes
                                // the old one, so no data was lost.
                                if (rx_if.Rd_en) begin
                                    overrun <= 1'b0;
                                end else begin
                                    overrun <= overrun | rx_ready;
                                end
                                state   <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BRK;
                            end
                        end
                    end
                end

                ST_BRK: begin
                    if (rx_s) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.Rx_data   = rx_data;
    assign rx_if.Rx_ready  = rx_ready;
    assign rx_if.Rx_busy   = rx_busy;
    assign rx_if.Frame_err = frame_err;
    assign rx_if.Overrun   = overrun;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver at 50 MHz / 115200 baud
//   (DIV = 27, nominal bit period 432 clocks).
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BIT_CLKS  = 432;
    localparam int FAST_CLKS = 424;   // transmitter 2% fast
    localparam int SLOW_CLKS = 441;   // transmitter 2% slow

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_HZ (50_000_000),
        .BAUD   (115200)
    ) dut (
        .clk_50m (clk),
        .clr     (clr),
        .rx_if   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one 8N1 frame, each bit held for bclk clocks; line stays at the
    // stop-bit level afterwards. Returns 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int bclk);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.Rx = fr[i];
            repeat (bclk) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rd_en();
        @(posedge clk); #1;
        bus.Rd_en = 1'b1;
        @(posedge clk); #1;
        bus.Rd_en = 1'b0;
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        bus.Rx    = 1'b1;
        bus.Rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.Rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", bus.Rx_data); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.Rx_busy); end
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", bus.Frame_err); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", bus.Overrun); end
        clr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", bus.Rx_busy); end
    endtask

    task automatic test_basic();
        send_byte(8'h55, 1'b1, BIT_CLKS);
        checks++; if (bus.Rx_data !== 8'h55) begin errors++; $display("FAIL basic_data got %h expected 55", bus.Rx_data); end
        checks++; if (bus.Rx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b expected 1", bus.Rx_ready); end
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b expected 0", bus.Frame_err); end
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b expected 0", bus.Rx_busy); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b expected 0", bus.Overrun); end
        pulse_rd_en();
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL basic_ack got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Rx_data !== 8'h55) begin errors++; $display("FAIL basic_hold got %h expected 55", bus.Rx_data); end
    endtask

    task automatic test_glitch();
        bus.Rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b expected 1", bus.Rx_busy); end
        repeat (50) @(posedge clk);
        #1;
        bus.Rx = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b expected 0", bus.Rx_busy); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b expected 0", bus.Frame_err); end
        checks++; if (bus.Rx_data !== 8'h55) begin errors++; $display("FAIL glitch_data got %h expected 55", bus.Rx_data); end
    endtask

    task automatic test_frame_err();
        send_byte(8'hA3, 1'b0, BIT_CLKS);
        checks++; if (bus.Frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b expected 1", bus.Frame_err); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL ferr_ready got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Rx_data !== 8'h55) begin errors++; $display("FAIL ferr_data got %h expected 55", bus.Rx_data); end
        repeat (2000) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b1) begin errors++; $display("FAIL brk_busy got %b expected 1", bus.Rx_busy); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL brk_ready got %b expected 0", bus.Rx_ready); end
        bus.Rx = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL brk_exit got %b expected 0", bus.Rx_busy); end
        send_byte(8'h3C, 1'b1, BIT_CLKS);
        checks++; if (bus.Rx_data !== 8'h3C) begin errors++; $display("FAIL after_brk_data got %h expected 3c", bus.Rx_data); end
        checks++; if (bus.Rx_ready !== 1'b1) begin errors++; $display("FAIL after_brk_ready got %b expected 1", bus.Rx_ready); end
        checks++; if (bus.Frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b expected 1", bus.Frame_err); end
        pulse_rd_en();
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b expected 0", bus.Frame_err); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL ferr_ack got %b expected 0", bus.Rx_ready); end
    endtask

    task automatic test_overrun();
        send_byte(8'h12, 1'b1, BIT_CLKS);
        checks++; if (bus.Rx_data !== 8'h12) begin errors++; $display("FAIL ovr_first_data got %h expected 12", bus.Rx_data); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %b expected 0", bus.Overrun); end
        send_byte(8'h34, 1'b1, BIT_CLKS);
        checks++; if (bus.Rx_data !== 8'h34) begin errors++; $display("FAIL ovr_data got %h expected 34", bus.Rx_data); end
        checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b expected 1", bus.Overrun); end
        checks++; if (bus.Rx_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready got %b expected 1", bus.Rx_ready); end
        pulse_rd_en();
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL ovr_ack_ready got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_flag got %b expected 0", bus.Overrun); end
    endtask

    task automatic test_mid_reset();
        logic [9:0] fr;
        fr = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.Rx = fr[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        bus.Rx = fr[5];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        checks++; if (bus.Rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", bus.Rx_busy); end
        clr    = 1'b1;
        bus.Rx = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++; if (bus.Rx_data !== 8'h00) begin errors++; $display("FAIL clr_data got %h expected 00", bus.Rx_data); end
        checks++; if (bus.Rx_busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b expected 0", bus.Rx_busy); end
        checks++; if (bus.Rx_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b expected 0", bus.Rx_ready); end
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL clr_ferr got %b expected 0", bus.Frame_err); end
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        send_byte(8'hC3, 1'b1, BIT_CLKS);
        checks++; if (bus.Rx_data !== 8'hC3) begin errors++; $display("FAIL post_clr_data got %h expected c3", bus.Rx_data); end
        checks++; if (bus.Rx_ready !== 1'b1) begin errors++; $display("FAIL post_clr_ready got %b expected 1", bus.Rx_ready); end
        checks++; if (bus.Frame_err !== 1'b0) begin errors++; $display("FAIL post_clr_ferr got %b expected 0", bus.Frame_err); end
        pulse_rd_en();
    endtask

    task automatic test_baud_skew();
        logic [7:0] vec [6];
        int         bclk;
        vec = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80};
        for (int i = 0; i < 6; i++) begin
            bclk = (i < 3) ? FAST_CLKS : SLOW_CLKS;
            send_byte(vec[i], 1'b1, bclk);
            checks++; if (bus.Rx_data !== vec[i]) begin errors++; $display("FAIL skew_data[%0d] got %h expected %h", i, bus.Rx_data, vec[i]); end
            checks++; if (bus.Rx_ready !== 1'b1) begin errors++; $display("FAIL skew_ready[%0d] got %b expected 1", i, bus.Rx_ready); end
            checks++; if ((bus.Frame_err | bus.Overrun) !== 1'b0) begin errors++; $display("FAIL skew_flags[%0d] got ferr=%b ovr=%b expected 0", i, bus.Frame_err, bus.Overrun); end
            pulse_rd_en();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_baud_skew();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_receiver
